// File: rtl/fetch_queue.sv
// Fetch stage: issues PC to synchronous instruction memory, queues returned words
// tagged with their address, and hands them to the decoder over valid/ready.
module fetch_queue #(
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned INSTR_W = 8,
   parameter int unsigned DEPTH   = 4
) (
   input  logic               clk,
   input  logic               nReset,
   input  logic [ADDR_W-1:0]  pc_addr,
   output logic               pc_hold,
   input  logic               flush,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_addr
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [ADDR_W-1:0]  addr;
      logic [INSTR_W-1:0] instr;
   } entry_t;

   entry_t             mem [DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   head_idx;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   count_nxt;
   logic               inflight;
   logic [ADDR_W-1:0]  inflight_addr;
   logic               issue;
   logic               push;
   logic               pop;
   entry_t             push_data;
   entry_t             head_nxt;
   entry_t             head_q;

   // Credit rule: an outstanding fetch reserves a slot, so a push never meets a full FIFO.
   assign pc_hold   = (count + CNT_W'(inflight)) >= CNT_W'(DEPTH);
   assign imem_addr = pc_addr;
   assign issue     = !pc_hold && !flush;
   assign push      = inflight && !flush;
   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready && !flush;
   assign push_data = '{addr: inflight_addr, instr: imem_rdata};
   assign out_instr = head_q.instr;
   assign out_addr  = head_q.addr;

   // Next head entry; bypass the word being written when the queue drains to it.
   always_comb begin
      count_nxt = count + CNT_W'(push) - CNT_W'(pop);
      head_idx  = rd_ptr + PTR_W'(pop);
      head_nxt  = mem[head_idx];
      if (push && ((count - CNT_W'(pop)) == '0)) begin
         head_nxt = push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Head is held in a register so the output keeps its last value while empty.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         count         <= '0;
         inflight      <= 1'b0;
         inflight_addr <= '0;
         head_q        <= '0;
      end else if (flush) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            inflight_addr <= pc_addr;
         end
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count_nxt;
         if (count_nxt != '0) begin
            head_q <= head_nxt;
         end
      end
   end

   a_no_overflow : assert property (@(posedge clk) disable iff (!nReset)
      push |-> (count < CNT_W'(DEPTH)));

endmodule
